mmio_console_ctrl: RTL

//  Synthesizable MMIO console/exit/watchdog controller on the core's dmem write port.

---
 rtl/mmio_console_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mmio_console_ctrl.sv
// mmio_console_ctrl: console / exit / watchdog controller sitting on the core's dmem write port.
// Decodes NCHAN putc channels and an exit register. It buffers characters in a tagged
// show-ahead FIFO, drains them over a valid/ready byte stream, and flags out-of-range
// writes and a stuck PC.
// Ports:
//   clk, resetb            clock, asynchronous active-low reset
//   wready/waddr/wdata     dmem write strobe, address and data from the core
//   wstall                 write held this cycle (putc hit while the FIFO is full)
//   pc, pc_valid           fetch PC and its qualifier, used by the watchdog
//   tx_valid/tx_ready      character stream handshake
//   tx_data/tx_chan        head character and its channel index
//   done, exit_code        exit written and FIFO drained; wdata of the exit write
//   timeout                sticky watchdog flag
//   range_err, err_addr    sticky out-of-range flag and address of the first offending write
module mmio_console_ctrl #(
    parameter int unsigned  NCHAN      = 2,
    parameter int unsigned  FIFO_DEPTH = 16,
    parameter logic [31:0]  PUTC_BASE  = 32'h8000_001c,
    parameter logic [31:0]  EXIT_ADDR  = 32'h8000_002c,
    parameter logic [31:0]  MEM_LIMIT  = 32'h0004_0000,
    parameter int unsigned  TIMEOUT    = 100,
    parameter int unsigned  WDT_W      = 8,
    localparam int unsigned CH_W       = $clog2(NCHAN) + ((NCHAN == 1) ? 1 : 0)
) (
    input  logic            clk,
    input  logic            resetb,
    input  logic            wready,
    input  logic [31:0]     waddr,
    input  logic [31:0]     wdata,
    output logic            wstall,
    input  logic [31:0]     pc,
    input  logic            pc_valid,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic [7:0]      tx_data,
    output logic [CH_W-1:0] tx_chan,
    output logic            done,
    output logic [31:0]     exit_code,
    output logic            timeout,
    output logic            range_err,
    output logic [31:0]     err_addr
);

    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned PW        = AW + 1;
    localparam int unsigned EW        = CH_W + 8;
    localparam logic [31:0] PUTC_SPAN = 32'(4 * NCHAN);
    localparam logic [WDT_W-1:0] WDT_MAX = {WDT_W{1'b1}};
    localparam logic [WDT_W-1:0] WDT_LIM = WDT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t          state;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [31:0]     last_pc;
    logic [WDT_W-1:0] wdt_cnt;

    logic [31:0]     putc_off;
    logic            putc_addr;
    logic            exit_addr;
    logic            putc_hit;
    logic            exit_hit;
    logic            range_hit;
    logic [CH_W-1:0] chan;
    logic [PW-1:0]   count;
    logic            full;
    logic            empty;
    logic            run;
    logic            push;
    logic            pop;
    logic            wdt_fire;
    logic [EW-1:0]   head;

    // Address decode and FIFO status
    always_comb begin
        putc_off  = waddr - PUTC_BASE;
        putc_addr = (waddr >= PUTC_BASE) && (putc_off < PUTC_SPAN) && (waddr[1:0] == 2'b00);
        exit_addr = (waddr == EXIT_ADDR);
        putc_hit  = wready && putc_addr;
        exit_hit  = wready && exit_addr;
        range_hit = wready && !putc_addr && !exit_addr && (waddr >= MEM_LIMIT);
        chan      = putc_off[2 +: CH_W];
        count     = wr_ptr - rd_ptr;
        full      = (count == PW'(FIFO_DEPTH));
        empty     = (wr_ptr == rd_ptr);
        run       = (state == S_RUN);
        push      = run && putc_hit && !full;
        pop       = !empty && tx_ready;
        wdt_fire  = run && (wdt_cnt == WDT_LIM);
        head      = mem[rd_ptr[AW-1:0]];
    end

    // Stall is combinational so the core holds the write in the same cycle
    assign wstall   = run && putc_hit && full;
    assign tx_valid = !empty;
    assign tx_data  = head[7:0];
    assign tx_chan  = head[EW-1:8];

    // Character storage; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {chan, wdata[7:0]};
        end
    end

    // Control state, pointers, watchdog and sticky flags
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state     <= S_RUN;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_pc   <= '0;
            wdt_cnt   <= '0;
            done      <= 1'b0;
            exit_code <= '0;
            timeout   <= 1'b0;
            range_err <= 1'b0;
            err_addr  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (pc_valid) begin
                last_pc <= pc;
            end
            case (state)
                S_RUN: begin
                    if (pc_valid && (pc == last_pc)) begin
                        wdt_cnt <= (wdt_cnt == WDT_MAX) ? wdt_cnt : wdt_cnt + WDT_W'(1);
                    end else begin
                        wdt_cnt <= '0;
                    end
                    // An exit write beats a watchdog expiry in the same cycle
                    if (exit_hit) begin
                        exit_code <= wdata;
                        state     <= S_DRAIN;
                    end else if (range_hit || wdt_fire) begin
                        state <= S_ERR;
                        if (range_hit && !range_err) begin
                            range_err <= 1'b1;
                            err_addr  <= waddr;
                        end
                        if (wdt_fire) begin
                            timeout <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (empty) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
